local_buf_stream_port: RTL and testbench
========================================

Name: local_buf_stream_port

Overview:
- Initiator side of the single-port URAM local buffer interface (address0/ce0/we0/d0/q0) used by the partialKnn kernels.
- Takes a command (base address, length, direction).
- For a write command, it moves an input stream into the buffer.
- For a read command, it issues pipelined reads and presents q0 data as a valid/ready output stream.
- Fixed memory read latency and output backpressure are handled with credit-based issue and a small return FIFO, so no read data is lost.

Parameters:
DataWidth, 256, data word width; equals memory DataWidth.
AddressWidth, 11, memory address width.
ReadLatency, 2, cycles from ce0 (we0=0) to valid q0; range 1..4.
FifoDepth, 4, return-FIFO entries; must be >= ReadLatency+1.

Ports:
clk  in  1  single clock.
reset_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  high only in IDLE.
cmd_write  in  1  1 = stream into memory, 0 = read out.
cmd_base  in  AddressWidth  first address.
cmd_len  in  AddressWidth+1  word count, 0..2^AddressWidth.
s_data  in  DataWidth  write-stream data.
s_valid  in  1  write-stream valid.
s_ready  out  1  write-stream ready.
m_data  out  DataWidth  read-stream data.
m_valid  out  1  read-stream valid.
m_ready  in  1  read-stream ready.
done  out  1  one-cycle pulse at command completion.
address0  out  AddressWidth  to memory.
ce0  out  1  to memory.
we0  out  1  to memory.
d0  out  DataWidth  to memory.
q0  in  DataWidth  from memory.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; counters, FIFO and in-flight pipe cleared.
  - cmd_ready=1; outputs s_ready, m_valid, done, ce0, we0 = 0; address0=0, d0=0.
- States: IDLE, WRITE, READ, DRAIN, FIN.
- IDLE:
  - Command accepted when cmd_valid & cmd_ready; latch base, len, dir.
  - len=0 -> FIN directly.
  - Otherwise -> WRITE or READ.
- WRITE:
  - s_ready=1.
  - Each s_valid cycle drives ce0=1, we0=1, address0=addr, d0=s_data (combinational pass-through) and increments addr.
  - After the len-th word -> FIN.
  - No stall cycles: one word per cycle when s_valid is held.
- READ:
  - Issue a read (ce0=1, we0=0, address0=addr) only when inflight + fifo_count < FifoDepth, counted including same-cycle pops.
  - A ReadLatency-deep valid shift register tracks in-flight reads.
  - Its tail pushes q0 into the return FIFO.
  - After the last issue -> DRAIN.
- DRAIN: no issue; waits until in-flight=0 and FIFO empty -> FIN.
- FIN: done=1 for exactly one cycle, then -> IDLE.
- Output stream:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - Pop on m_valid & m_ready.
  - m_data is held stable while m_valid & !m_ready.
  - Push and pop in the same cycle are allowed, including when full and when empty with bypass disabled (data appears the cycle after push).
- Read throughput: one word per cycle with m_ready held high.
- First m_valid appears ReadLatency+1 cycles after the first ce0.
- Address wraps modulo 2^AddressWidth (base + i truncated). len = 2^AddressWidth covers the full buffer exactly once.
- ce0 is never asserted outside WRITE/READ. we0=1 only in WRITE.
- Commands arriving during a busy period are not accepted (cmd_ready=0).
- Reset mid-command: immediate abort, no done pulse. In-flight memory returns are discarded.

Test Plan:
- Write base=0x010, len=8, s_valid constant with data 0xA0..0xA7 -> ce0=we0=1 for 8 consecutive cycles, addresses 0x010..0x017, done exactly one cycle after the last write.
- Read back base=0x010, len=8, m_ready=1, ReadLatency=2 -> m_data 0xA0..0xA7 in order on consecutive cycles, first m_valid 3 cycles after the first ce0, then done.
- Same read with m_ready toggling 1,0,0,1 -> no loss or duplication; never more than FifoDepth (4) outstanding+buffered; m_data stable while stalled.
- Wrap: write base=0x7FE, len=4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001; readback matches.
- len=0 read and write -> no ce0 activity; done asserted the cycle after acceptance; cmd_ready high again the next cycle.
- Assert reset_n=0 mid-READ with 3 words in flight -> ce0/m_valid/done drop immediately; after release, cmd_ready=1 and a new 2-word read returns correct data only.

Source files
------------

// File: rtl/local_buf_stream_port.sv
// Initiator for the single-port URAM local buffer: streams a command's words into the
// buffer, or issues credit-limited pipelined reads and returns q0 as a valid/ready stream.
module local_buf_stream_port #(
  parameter int unsigned DataWidth    = 256,
  parameter int unsigned AddressWidth = 11,
  parameter int unsigned ReadLatency  = 2,
  parameter int unsigned FifoDepth    = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [AddressWidth-1:0] cmd_base,
  input  logic [AddressWidth:0]   cmd_len,
  input  logic [DataWidth-1:0]    s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DataWidth-1:0]    m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    done,
  output logic [AddressWidth-1:0] address0,
  output logic                    ce0,
  output logic                    we0,
  output logic [DataWidth-1:0]    d0,
  input  logic [DataWidth-1:0]    q0
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_FIN
  } state_t;

  state_t                  state_q, state_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [AddressWidth:0]   remain_q, remain_d;
  logic [ReadLatency-1:0]  pipe_q, pipe_d;
  logic [DataWidth-1:0]    fifo_q [FifoDepth];
  logic [DataWidth-1:0]    fifo_d [FifoDepth];
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [CntW-1:0]         inflight;
  logic [CntW:0]           occupancy;
  logic                    push, pop, issue;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ReadLatency; i++) begin
      inflight = inflight + CntW'(pipe_q[i]);
    end
  end

  assign push    = pipe_q[ReadLatency-1];
  assign m_valid = (count_q != '0);
  assign m_data  = fifo_q[rd_ptr_q];
  assign pop     = m_valid & m_ready;
  // A credit freed by this cycle's pop can be reused immediately, so reads in flight
  // plus buffered words never exceed FifoDepth and every return has a slot.
  assign occupancy = {1'b0, inflight} + {1'b0, count_q} - (CntW + 1)'(pop);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    done      = 1'b0;
    ce0       = 1'b0;
    we0       = 1'b0;
    address0  = '0;
    d0        = '0;
    issue     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d   = cmd_base;
          remain_d = cmd_len;
          if (cmd_len == '0)  state_d = ST_FIN;
          else if (cmd_write) state_d = ST_WRITE;
          else                state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          ce0      = 1'b1;
          we0      = 1'b1;
          address0 = addr_q;
          d0       = s_data;
          addr_d   = addr_q + AddressWidth'(1);
          remain_d = remain_q - (AddressWidth + 1)'(1);
          if (remain_q == (AddressWidth + 1)'(1)) state_d = ST_FIN;
        end
      end
      ST_READ: begin
        if (occupancy < (CntW + 1)'(FifoDepth)) begin
          issue    = 1'b1;
          ce0      = 1'b1;
          address0 = addr_q;
          addr_d   = addr_q + AddressWidth'(1);
          remain_d = remain_q - (AddressWidth + 1)'(1);
          if (remain_q == (AddressWidth + 1)'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight == '0 && count_q == '0) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = issue;
    for (int unsigned i = 1; i < ReadLatency; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = q0;
      wr_ptr_d         = ptr_next(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_next(rd_ptr_q);
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      pipe_q   <= '0;
      fifo_q   <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      pipe_q   <= pipe_d;
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_local_buf_stream_port.sv
// Randomized bench for local_buf_stream_port: a latency-2 memory model on the port side,
// and a reference image of the buffer built from the stimulus to predict read data.
module tb_local_buf_stream_port;

  localparam int unsigned DW = 256;
  localparam int unsigned AW = 11;
  localparam int unsigned RL = 2;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready;
  logic          done;
  logic [AW-1:0] address0;
  logic          ce0, we0;
  logic [DW-1:0] d0, q0;

  logic [DW-1:0] mem     [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] rd1, rd2;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  local_buf_stream_port #(
    .DataWidth   (DW),
    .AddressWidth(AW),
    .ReadLatency (RL),
    .FifoDepth   (FD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_base (cmd_base),
    .cmd_len  (cmd_len),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .done     (done),
    .address0 (address0),
    .ce0      (ce0),
    .we0      (we0),
    .d0       (d0),
    .q0       (q0)
  );

  always #5 clk = ~clk;

  // Single-port memory with two-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ce0 && we0) mem[address0] <= d0;
    if (ce0 && !we0) rd1 <= mem[address0];
    rd2 <= rd1;
  end
  assign q0 = rd2;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w = '0;
    for (int k = 0; k < DW / 32; k++) w = {w[DW-33:0], $urandom};
    return w;
  endfunction

  task automatic issue_cmd(input logic wr, input logic [AW-1:0] base, input int unsigned len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_base  = base;
    cmd_len   = (AW + 1)'(len);
    @(negedge clk);
    chk("cmd_ready_idle", DW'(cmd_ready), DW'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_base  = AW'($urandom);
    cmd_len   = (AW + 1)'($urandom);
  endtask

  task automatic post_done();
    @(negedge clk);
    chk("done_one_cycle", DW'(done), '0);
    chk("cmd_ready_again", DW'(cmd_ready), DW'(1));
    chk("idle_ce0", DW'(ce0), '0);
    chk("idle_m_valid", DW'(m_valid), '0);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] base, input int unsigned len, input bit rnd);
    int unsigned   i = 0;
    int unsigned   guard = 0;
    logic [DW-1:0] w;
    issue_cmd(1'b1, base, len);
    w = rnd ? rand_word() : DW'(32'hA0);
    while (i < len && guard < 4 * len + 20) begin
      s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = s_valid ? w : rand_word();
      @(negedge clk);
      chk("wr_s_ready", DW'(s_ready), DW'(1));
      if (s_valid) begin
        chk("wr_ce0", DW'(ce0), DW'(1));
        chk("wr_we0", DW'(we0), DW'(1));
        chk("wr_addr", DW'(address0), DW'(AW'(base + i)));
        chk("wr_d0", d0, w);
        ref_mem[AW'(base + i)] = w;
        i++;
        w = rnd ? rand_word() : DW'(32'hA0 + i);
      end else begin
        chk("wr_gap_ce0", DW'(ce0), '0);
      end
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0;
    if (i < len) chk("wr_timeout", '0, DW'(1));
    @(negedge clk);
    chk("wr_done", DW'(done), DW'(1));
    chk("wr_done_ce0", DW'(ce0), '0);
    @(posedge clk); #1;
    post_done();
  endtask

  // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random, 3 never ready.
  task automatic do_read(input logic [AW-1:0] base, input int unsigned len,
                         input int unsigned mode, input int unsigned abort_at);
    int unsigned   issued = 0;
    int unsigned   popped = 0;
    int unsigned   guard = 0;
    int unsigned   ph = 0;
    int            first_ce = -1;
    int            first_mv = -1;
    int            first_pop = -1;
    int            last_pop = -1;
    bit            held_v = 1'b0;
    bit            fin = 1'b0;
    logic [DW-1:0] held_d = '0;
    issue_cmd(1'b0, base, len);
    if (len == 0) begin
      @(negedge clk);
      chk("rd_len0_done", DW'(done), DW'(1));
      chk("rd_len0_ce0", DW'(ce0), '0);
      @(posedge clk); #1;
      post_done();
      return;
    end
    while (!fin && guard < 8 * len + 40) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (ph % 4 == 0) || (ph % 4 == 3);
        2:       m_ready = ($urandom_range(0, 1) == 1);
        default: m_ready = 1'b0;
      endcase
      ph++;
      @(negedge clk);
      if (held_v) begin
        chk("rd_stall_valid", DW'(m_valid), DW'(1));
        chk("rd_stall_data", m_data, held_d);
      end
      if (ce0) begin
        chk("rd_we0", DW'(we0), '0);
        chk("rd_addr", DW'(address0), DW'(AW'(base + issued)));
        chk("rd_overissue", DW'(issued < len), DW'(1));
        if (issued == 0) first_ce = cyc;
        issued++;
      end
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (m_valid && m_ready) begin
        chk("rd_data", m_data, ref_mem[AW'(base + popped)]);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        popped++;
      end
      chk("rd_outstanding", DW'(issued - popped <= FD), DW'(1));
      held_v = m_valid && !m_ready;
      held_d = m_data;
      if (done) begin
        fin = 1'b1;
        chk("rd_done_issued", DW'(issued), DW'(len));
        chk("rd_done_popped", DW'(popped), DW'(len));
      end
      if (abort_at != 0 && issued >= abort_at) return;
      if (!fin) begin
        @(posedge clk); #1;
      end
      guard++;
    end
    m_ready = 1'b0;
    if (!fin) begin
      chk("rd_timeout", '0, DW'(1));
    end else begin
      chk("rd_first_latency", DW'(first_mv - first_ce), DW'(RL + 1));
      if (mode == 0) chk("rd_throughput", DW'(last_pop - first_pop), DW'(len - 1));
    end
    @(posedge clk); #1;
    post_done();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", DW'(cmd_ready), DW'(1));
    chk("rst_s_ready", DW'(s_ready), '0);
    chk("rst_m_valid", DW'(m_valid), '0);
    chk("rst_done", DW'(done), '0);
    chk("rst_ce0", DW'(ce0), '0);
    chk("rst_we0", DW'(we0), '0);
    chk("rst_address0", DW'(address0), '0);
    chk("rst_d0", d0, '0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_write(11'h010, 8, 1'b0);
    do_read(11'h010, 8, 0, 0);
    do_read(11'h010, 8, 1, 0);

    do_write(11'h7FE, 4, 1'b0);
    do_read(11'h7FE, 4, 0, 0);

    do_write(11'h100, 0, 1'b0);
    do_read(11'h100, 0, 0, 0);

    // Abort a stalled read with returns still in the memory pipe.
    do_read(11'h010, 8, 3, 3);
    @(posedge clk); #2;
    chk("abort_pre_m_valid", DW'(m_valid), DW'(1));
    chk("abort_pre_ce0", DW'(ce0), DW'(1));
    reset_n = 1'b0;
    #1;
    chk("abort_ce0", DW'(ce0), '0);
    chk("abort_m_valid", DW'(m_valid), '0);
    chk("abort_done", DW'(done), '0);
    chk("abort_cmd_ready", DW'(cmd_ready), DW'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_read(11'h7FF, 2, 0, 0);

    for (int n = 0; n < 8; n++) begin
      logic [AW-1:0] b;
      int unsigned   l;
      b = AW'($urandom);
      l = $urandom_range(1, 24);
      do_write(b, l, 1'b1);
      do_read(b, l, $urandom_range(0, 2), 0);
    end

    do_write(11'h000, 2**AW, 1'b1);
    do_read(AW'($urandom), 2**AW, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
